// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one main-memory port between external storage, I-cache and D-cache.
// Optional watchdog enabled by defining MEMARB_WATCHDOG_EN.
module mem_rr_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2:0]              m_enable,
   input  logic [2:0]              m_rw,
   input  logic [3*ADDR_WIDTH-1:0] m_addr,
   input  logic [3*DATA_WIDTH-1:0] m_write,
   output logic [2:0]              m_grant,
   output logic [2:0]              m_req_data,
   output logic [DATA_WIDTH-1:0]   m_read,
   output logic [2:0]              m_read_valid,
   output logic [2:0]              m_last,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic                    mem_enable,
   output logic                    mem_rw,
   output logic [DATA_WIDTH-1:0]   mem_write,
   input  logic                    mem_write_req_input,
   input  logic [DATA_WIDTH-1:0]   mem_read,
   input  logic                    mem_read_valid,
   input  logic                    mem_last,
   output logic                    busy,
   output logic [7:0]              last_beats,
   output logic                    bus_error
);

   localparam logic MEM_READ = 1'b0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [1:0] state_q, state_d;
   logic [2:0] grant_q, grant_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic [7:0] last_beats_q, last_beats_d;

   logic                  in_busy;
   logic                  beat;
   logic                  timeout;
   logic                  burst_end;
   logic [1:0]            gidx;
   logic [1:0]            ptr_next;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  sel_rw;

   function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
      if (en && (v != 8'hFF)) return v + 8'd1;
      return v;
   endfunction

   // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
   function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
      logic [5:0] dbl;
      logic [2:0] rot;
      logic [2:0] sel;
      dbl = {req, req};
      case (ptr)
         2'd1:    rot = dbl[3:1];
         2'd2:    rot = dbl[4:2];
         default: rot = dbl[2:0];
      endcase
      sel = rot[0] ? 3'b001 : (rot[1] ? 3'b010 : (rot[2] ? 3'b100 : 3'b000));
      dbl = {sel, sel};
      case (ptr)
         2'd1:    return dbl[4:2];
         2'd2:    return dbl[3:1];
         default: return sel;
      endcase
   endfunction

   assign in_busy   = (state_q == ST_BUSY);
   assign beat      = mem_read_valid | mem_write_req_input;
   assign burst_end = in_busy & (mem_last | timeout);

   always_comb begin
      gidx = 2'd0;
      if (grant_q[1])      gidx = 2'd1;
      else if (grant_q[2]) gidx = 2'd2;
   end

   assign ptr_next = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;

   always_comb begin
      sel_addr  = m_addr[0 +: ADDR_WIDTH];
      sel_wdata = m_write[0 +: DATA_WIDTH];
      sel_rw    = m_rw[0];
      if (gidx == 2'd1) begin
         sel_addr  = m_addr[ADDR_WIDTH +: ADDR_WIDTH];
         sel_wdata = m_write[DATA_WIDTH +: DATA_WIDTH];
         sel_rw    = m_rw[1];
      end else if (gidx == 2'd2) begin
         sel_addr  = m_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
         sel_wdata = m_write[2*DATA_WIDTH +: DATA_WIDTH];
         sel_rw    = m_rw[2];
      end
   end

`ifdef MEMARB_WATCHDOG_EN
   logic [7:0] idle_cnt_q, idle_cnt_d;
   logic       bus_error_q, bus_error_d;

   assign timeout = in_busy && (idle_cnt_q == 8'(TIMEOUT));

   // Counter is held at zero while idle, so it starts from zero on every grant.
   always_comb begin
      idle_cnt_d  = idle_cnt_q;
      bus_error_d = bus_error_q | timeout;
      if (state_q == ST_IDLE) idle_cnt_d = 8'd0;
      else if (in_busy)       idle_cnt_d = beat ? 8'd0 : sat_inc(idle_cnt_q, 1'b1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_q  <= 8'd0;
         bus_error_q <= 1'b0;
      end else begin
         idle_cnt_q  <= idle_cnt_d;
         bus_error_q <= bus_error_d;
      end
   end

   assign bus_error = bus_error_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^8'(TIMEOUT);
   assign timeout        = 1'b0;
   assign bus_error      = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      ptr_d        = ptr_q;
      beat_cnt_d   = beat_cnt_q;
      last_beats_d = last_beats_q;
      case (state_q)
         ST_IDLE: begin
            if (m_enable != 3'b000) begin
               grant_d    = rr_pick(m_enable, ptr_q);
               beat_cnt_d = 8'd0;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            beat_cnt_d = sat_inc(beat_cnt_q, beat);
            if (burst_end) begin
               last_beats_d = sat_inc(beat_cnt_q, beat);
               ptr_d        = ptr_next;
               grant_d      = 3'b000;
               state_d      = ST_GAP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= 3'b000;
         ptr_q        <= 2'd0;
         beat_cnt_q   <= 8'd0;
         last_beats_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         ptr_q        <= ptr_d;
         beat_cnt_q   <= beat_cnt_d;
         last_beats_q <= last_beats_d;
      end
   end

   // RAM strobes pass straight through to the granted master only.
   assign m_grant      = grant_q;
   assign m_read       = mem_read;
   assign m_read_valid = in_busy ? (grant_q & {3{mem_read_valid}})      : 3'b000;
   assign m_req_data   = in_busy ? (grant_q & {3{mem_write_req_input}}) : 3'b000;
   assign m_last       = burst_end ? grant_q : 3'b000;

   assign mem_enable = in_busy;
   assign mem_rw     = in_busy ? sel_rw : MEM_READ;
   assign mem_addr   = sel_addr;
   assign mem_write  = sel_wdata;
   assign busy       = (state_q != ST_IDLE);
   assign last_beats = last_beats_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Testbench for mem_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_mem_rr_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 16;
   localparam int WD_T = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    m_enable, m_rw;
   logic [3*AW-1:0] m_addr;
   logic [3*DW-1:0] m_write;
   logic [2:0]    m_grant, m_req_data, m_read_valid, m_last;
   logic [DW-1:0] m_read;
   logic [AW-1:0] mem_addr;
   logic          mem_enable, mem_rw;
   logic [DW-1:0] mem_write;
   logic          mem_write_req_input, mem_read_valid, mem_last;
   logic [DW-1:0] mem_read;
   logic          busy;
   logic [7:0]    last_beats;
   logic          bus_error;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Behavioural model: who owns the bus, whether a gap cycle is pending, and who is next in line.
   int owner, gap, rr_next, beats, wd, exp_lb;
   bit exp_err;

   mem_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(WD_T)) dut (
      .clk(clk), .rst(rst),
      .m_enable(m_enable), .m_rw(m_rw), .m_addr(m_addr), .m_write(m_write),
      .m_grant(m_grant), .m_req_data(m_req_data), .m_read(m_read),
      .m_read_valid(m_read_valid), .m_last(m_last),
      .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_write(mem_write),
      .mem_write_req_input(mem_write_req_input), .mem_read(mem_read),
      .mem_read_valid(mem_read_valid), .mem_last(mem_last),
      .busy(busy), .last_beats(last_beats), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] onehot(input int i);
      if (i < 0) return 3'b000;
      return 3'(1 << i);
   endfunction

   function automatic bit wd_hit();
`ifdef MEMARB_WATCHDOG_EN
      return (owner >= 0) && (wd == WD_T);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      owner = -1; gap = 0; rr_next = 0; beats = 0; wd = 0; exp_lb = 0; exp_err = 1'b0;
   endtask

   task automatic model_step();
      int b;
      bit hit;
      b   = (mem_read_valid || mem_write_req_input) ? 1 : 0;
      hit = wd_hit();
      if (rst) begin
         model_reset();
      end else if (owner >= 0) begin
         if (mem_last || hit) begin
            exp_lb  = (beats + b > 255) ? 255 : beats + b;
            rr_next = (owner + 1) % 3;
            owner   = -1;
            gap     = 1;
            if (hit) exp_err = 1'b1;
         end else begin
            beats = (beats + b > 255) ? 255 : beats + b;
            wd    = (b != 0) ? 0 : wd + 1;
         end
      end else if (gap != 0) begin
         gap = 0;
      end else if (m_enable != 3'b000) begin
         for (int k = 0; k < 3; k++) begin
            int i;
            i = (rr_next + k) % 3;
            if (owner < 0 && ((m_enable >> i) & 3'b001) != 3'b000) owner = i;
         end
         beats = 0;
         wd    = 0;
      end
   endtask

   // Check every output against the model for the current cycle, then advance one clock.
   task automatic tick();
      logic [2:0] g;
      bit         own;
      #2;
      own = (owner >= 0);
      g   = onehot(owner);
      chk("m_grant", 64'(m_grant), 64'(g));
      chk("mem_enable", 64'(mem_enable), 64'(own));
      chk("busy", 64'(busy), 64'(own || gap != 0));
      chk("last_beats", 64'(last_beats), 64'(exp_lb));
      chk("bus_error", 64'(bus_error), 64'(exp_err));
      chk("m_read", 64'(m_read), 64'(mem_read));
      chk("m_read_valid", 64'(m_read_valid), 64'(mem_read_valid ? g : 3'b000));
      chk("m_req_data", 64'(m_req_data), 64'(mem_write_req_input ? g : 3'b000));
      chk("m_last", 64'(m_last), 64'((mem_last || wd_hit()) ? g : 3'b000));
      if (own) begin
         chk("mem_rw", 64'(mem_rw), 64'((m_rw >> owner) & 3'b001));
         chk("mem_addr", 64'(mem_addr), 64'(AW'(m_addr >> (owner * AW))));
         chk("mem_write", 64'(mem_write), 64'(DW'(m_write >> (owner * DW))));
      end else begin
         chk("mem_rw_idle", 64'(mem_rw), 64'(0));
      end
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic drive(input logic [2:0] en, input logic [2:0] rw, input logic rv,
                        input logic wr, input logic last, input int n);
      for (int i = 0; i < n; i++) begin
         m_enable = en; m_rw = rw;
         mem_read_valid = rv; mem_write_req_input = wr; mem_last = last;
         m_addr   = {16'($urandom), 16'($urandom), 16'($urandom)};
         m_write  = {$urandom, $urandom, $urandom};
         mem_read = $urandom;
         tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2);
      rst = 1'b0;
   endtask

   initial begin
      logic [2:0] order [4];
      order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

      rst = 1'b1;
      m_enable = '0; m_rw = '0; m_addr = '0; m_write = '0;
      mem_read_valid = 1'b0; mem_write_req_input = 1'b0; mem_last = 1'b0; mem_read = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      do_reset();
      chk("reset_grant", 64'(m_grant), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_last_beats", 64'(last_beats), 64'(0));

      // Single requester, 8 read beats
      drive(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1);
      chk("single_grant", 64'(m_grant), 64'(3'b010));
      drive(3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 7);
      drive(3'b010, 3'b000, 1'b1, 1'b0, 1'b1, 1);
      chk("single_gap_enable", 64'(mem_enable), 64'(0));
      chk("single_last_beats", 64'(last_beats), 64'(8));
      drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2);

      // All three requesting, 1-beat bursts, rotation from a fresh pointer
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(3'b111, 3'b000, 1'b1, 1'b0, 1'b1, 1);
         chk("rr_order", 64'(m_grant), 64'(order[k]));
         drive(3'b111, 3'b000, 1'b1, 1'b0, 1'b1, 1);
         drive(3'b111, 3'b000, 1'b1, 1'b0, 1'b1, 1);
         chk("rr_gap_grant", 64'(m_grant), 64'(0));
      end
      drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1);

      // Write burst from data cache, 4 write-data requests
      drive(3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 1);
      for (int k = 0; k < 3; k++) begin
         drive(3'b100, 3'b100, 1'b0, 1'b1, 1'b0, 1);
         drive(3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 1);
      end
      drive(3'b100, 3'b100, 1'b0, 1'b1, 1'b1, 1);
      chk("write_last_beats", 64'(last_beats), 64'(4));
      drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2);

      // Request dropped mid-burst: grant holds until mem_last
      drive(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 1);
      drive(3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 2);
      drive(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3);
      chk("drop_grant_held", 64'(m_grant), 64'(3'b001));
      drive(3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 1);
      drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2);

      // Reset mid-burst
      drive(3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 1);
      drive(3'b011, 3'b000, 1'b1, 1'b0, 1'b0, 2);
      rst = 1'b1;
      drive(3'b011, 3'b000, 1'b1, 1'b0, 1'b0, 1);
      rst = 1'b0;
      chk("midrst_grant", 64'(m_grant), 64'(0));
      chk("midrst_enable", 64'(mem_enable), 64'(0));
      drive(3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1);
      chk("midrst_ptr0", 64'(m_grant), 64'(3'b001));
      drive(3'b111, 3'b000, 1'b1, 1'b0, 1'b1, 1);
      drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2);

      // mem_last and a new request in the same cycle
      drive(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 1);
      drive(3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 2);
      drive(3'b011, 3'b000, 1'b1, 1'b0, 1'b1, 1);
      drive(3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 1);
      chk("simul_gap_grant", 64'(m_grant), 64'(0));
      drive(3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 1);
      chk("simul_new_grant", 64'(m_grant), 64'(3'b010));
      drive(3'b011, 3'b000, 1'b1, 1'b0, 1'b1, 1);
      drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2);

`ifdef MEMARB_WATCHDOG_EN
      // Watchdog: granted master never gets a beat or mem_last
      drive(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 1);
      drive(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, WD_T);
      chk("wd_m_last", 64'(m_last), 64'(3'b001));
      drive(3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 1);
      chk("wd_bus_error", 64'(bus_error), 64'(1));
      drive(3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 2);
      chk("wd_next_grant", 64'(m_grant), 64'(3'b010));
      drive(3'b011, 3'b000, 1'b1, 1'b0, 1'b1, 1);
      drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2);
      chk("wd_sticky", 64'(bus_error), 64'(1));
`endif

      // Beat counter saturates on a very long burst
      drive(3'b100, 3'b000, 1'b0, 1'b0, 1'b0, 1);
      drive(3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 259);
      drive(3'b100, 3'b000, 1'b1, 1'b0, 1'b1, 1);
      chk("sat_last_beats", 64'(last_beats), 64'(255));
      drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         drive(3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter that shares the single main-memory port between three burst masters: external storage, instruction cache and data cache. It replaces fixed-priority selection with fair rotation. It holds each grant for one whole burst, terminated by `mem_last`, and inserts a one-cycle bus turnaround between bursts. It sits between the cache/external-storage front ends and the RAM model, and muxes address, control and data in both directions.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width.
- `ADDR_WIDTH`, 16: main-memory address width.
- `TIMEOUT`, 255: watchdog limit in cycles without a beat; range 1..255. Used only with `MEMARB_WATCHDOG_EN`.

Ports:
- `clk`  in  1: the single clock. All logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `m_enable`  in  3: per-master request. Bit0 = external, bit1 = inst cache, bit2 = data cache.
- `m_rw`  in  3: per-master direction, using `MEM_READ`/`MEM_WRITE` encoding.
- `m_addr`  in  3*ADDR_WIDTH: packed addresses. Master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `m_write`  in  3*DATA_WIDTH: packed write data, sliced the same way.
- `m_grant`  out  3: one-hot registered grant.
- `m_req_data`  out  3: per-master write-data request, taken from `mem_write_req_input`.
- `m_read`  out  DATA_WIDTH: read data, broadcast to all masters.
- `m_read_valid`  out  3: per-master read strobe.
- `m_last`  out  3: per-master end-of-burst strobe.
- `mem_addr`  out  ADDR_WIDTH, `mem_enable`  out  1, `mem_rw`  out  1, `mem_write`  out  DATA_WIDTH: RAM request.
- `mem_write_req_input`  in  1, `mem_read`  in  DATA_WIDTH, `mem_read_valid`  in  1, `mem_last`  in  1: RAM response.
- `busy`  out  1: high in BUSY and GAP.
- `last_beats`  out  8: beat count of the most recently completed burst.
- `bus_error`  out  1: sticky watchdog flag.

## Operation
State machine has three states: IDLE, BUSY, GAP.

- **IDLE**
  - If `m_enable` != 0, select the first set bit scanning upward, circularly, from `ptr`.
  - Register the one-hot grant into `m_grant` and go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - Drive `mem_enable`=1. Drive `mem_addr`, `mem_rw`, `mem_write` from the granted slice.
  - Route `mem_read_valid`, `mem_write_req_input` and `mem_last` only to the granted bit of `m_read_valid`, `m_req_data` and `m_last`. All other bits are 0.
  - A beat is any cycle with `mem_read_valid | mem_write_req_input`. Beats are counted in `beat_cnt` (8 bits, saturating at 255).
  - On `mem_last`:
    - `last_beats` is loaded with `beat_cnt`, plus 1 if the final cycle is itself a beat.
    - `ptr` becomes (granted index + 1) mod 3.
    - `m_grant` clears and the state goes to GAP.
- **GAP**: one cycle with `mem_enable`=0. Always returns to IDLE. No new grant is issued in GAP.

Rules:
- Deasserting `m_enable` during BUSY is ignored. The grant holds until `mem_last`.
- Outside BUSY:
  - `mem_enable`=0.
  - `mem_addr`, `mem_write` and `m_read` are don't-care.
  - `mem_rw`=`MEM_READ`.
- `m_read` equals `mem_read` combinationally at all times.
- Reset values:
  - `m_grant`=0, `m_req_data`=0, `m_read_valid`=0, `m_last`=0.
  - `mem_enable`=0, `busy`=0, `last_beats`=0, `bus_error`=0.
  - `ptr`=0 (external first), state IDLE.
- Reset mid-burst aborts immediately. No `m_last` is issued. Masters and RAM must be reset by the same `rst`.

## Timing
- Request sampled at edge n gives grant and `mem_enable` from cycle n+1.
- All RAM-to-master strobes are combinational pass-through: zero added latency.
- A master-to-master handover costs 2 cycles:
  - the `mem_last` cycle, then
  - GAP, then
  - the next IDLE sample, with the grant at the following edge.
- Worst-case wait for a requester is 2 other bursts plus 2×3 overhead cycles. No starvation is possible.
- `mem_last` asserted in the first BUSY cycle is legal and gives a one-cycle burst.

## Configuration
- `MEMARB_WATCHDOG_EN` defined:
  - An 8-bit idle counter runs in BUSY. It clears on grant and on every beat.
  - When it reaches `TIMEOUT`, the arbiter behaves as if `mem_last` occurred:
    - pulses the granted `m_last` for 1 cycle;
    - drops `mem_enable`;
    - goes to GAP;
    - advances `ptr`;
    - sets `bus_error`=1 until `rst`.
- `MEMARB_WATCHDOG_EN` not defined:
  - No counter. `bus_error` is tied to 0.
  - BUSY waits for `mem_last` indefinitely.

## Test plan
- **Single requester.** Reset, then `m_enable`=3'b010 with 8 read beats, `mem_last` on beat 8.
  - `m_grant`=010 one cycle after the request.
  - 8 `m_read_valid[1]` pulses.
  - `last_beats`=8; GAP has `mem_enable`=0.
- **All three requesting.** `m_enable`=3'b111 held continuously, 1-beat bursts.
  - Grant order is 001, 010, 100, 001, …
  - Each grant is separated by the 2-cycle handover.
- **Write burst from data cache.** `m_rw[2]`=write, 4 `mem_write_req_input` pulses.
  - `m_req_data[2]` mirrors each pulse; the other bits stay 0.
  - `mem_write` equals the `m_write` slice 2.
- **Request drop and reset mid-burst.**
  - Drop `m_enable[0]` mid-burst: the grant holds until `mem_last`.
  - Assert `rst` mid-burst: the next cycle has all outputs 0 and `ptr`=0.
- **Watchdog** (`MEMARB_WATCHDOG_EN`, `TIMEOUT`=16). Grant with no beats and no `mem_last`.
  - `m_last` pulses 16 cycles after the grant.
  - `bus_error`=1 and stays set.
  - The next requester is granted.
- **Simultaneous last and new request.** `mem_last` and a new `m_enable` bit rise in the same cycle.
  - The new grant appears exactly 2 cycles later.
  - Arbitration starts from the advanced `ptr`.
